// File: rtl/io_pkg.sv
// Shared constants for the SoC I/O responder: address map, prescaler defaults,
// seven-segment glyph table and the address-decode helper.
package io_pkg;

    localparam logic [31:0] ADDR_DIG   = 32'hFFFF_F000;
    localparam logic [31:0] ADDR_TIMER = 32'hFFFF_F020;
    localparam logic [31:0] ADDR_LED   = 32'hFFFF_F060;
    localparam logic [31:0] ADDR_SW    = 32'hFFFF_F070;
    localparam logic [31:0] ADDR_BTN   = 32'hFFFF_F078;

    localparam int SCAN_DIV_DEF = 20000;
    localparam int TICK_DIV_DEF = 100000;

    // Active-low glyphs, bit 0 = a ... bit 6 = g, bit 7 = dp (kept high)
    localparam logic [15:0][7:0] SEG_LUT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_DIG,
        SEL_TIMER,
        SEL_LED,
        SEL_SW,
        SEL_BTN
    } reg_sel_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
    } io_req_t;

    function automatic logic [7:0] hex2seg(input logic [3:0] nib);
        return SEG_LUT[nib];
    endfunction

    function automatic reg_sel_e decode_addr(input logic [31:0] addr);
        reg_sel_e sel;
        case (addr)
            ADDR_DIG:   sel = SEL_DIG;
            ADDR_TIMER: sel = SEL_TIMER;
            ADDR_LED:   sel = SEL_LED;
            ADDR_SW:    sel = SEL_SW;
            ADDR_BTN:   sel = SEL_BTN;
            default:    sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/seg7_scan.sv
// Eight-digit seven-segment scanner: prescaler, digit index, nibble select and
// registered an/seg drive.
module seg7_scan
    import io_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dig,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] pre;
    logic [2:0]    idx;
    logic          wrap;
    logic [3:0]    nib;

    assign wrap = (pre == PW'(SCAN_DIV - 1));
    assign nib  = dig[{idx, 2'b00} +: 4];

    // an/seg lag idx by one edge, so each digit still dwells SCAN_DIV cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            idx <= '0;
            an  <= 8'hFE;
            seg <= 8'hC0;
        end else begin
            pre <= wrap ? '0 : pre + PW'(1);
            if (wrap)
                idx <= idx + 3'd1;
            an  <= ~(8'd1 << idx);
            seg <= hex2seg(nib);
        end
    end

endmodule

// File: rtl/io_responder.sv
// Memory-mapped I/O responder: register file, input synchronisers, tick timer,
// combinational read mux and the display scanner.
module io_responder
    import io_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEF,
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] io_addr,
    input  logic        io_rd_e,
    input  logic        io_wr_e,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    input  logic [23:0] sw,
    input  logic [4:0]  btn,
    output logic [23:0] led,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    io_req_t  req;
    reg_sel_e sel;
    logic     wr_dig, wr_led, wr_timer;

    assign req      = '{addr: io_addr, rd: io_rd_e, wr: io_wr_e, wdata: io_wdata};
    assign sel      = decode_addr(req.addr);
    assign wr_dig   = req.wr && (sel == SEL_DIG);
    assign wr_led   = req.wr && (sel == SEL_LED);
    assign wr_timer = req.wr && (sel == SEL_TIMER);

    logic [31:0] dig_q;
    logic [23:0] led_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_q <= '0;
            led_q <= '0;
        end else begin
            if (wr_dig)
                dig_q <= req.wdata;
            if (wr_led)
                led_q <= req.wdata[23:0];
        end
    end

    assign led = led_q;

    // Two-flop synchronisers; stage [1] is the one software sees
    logic [1:0][23:0] sw_pipe;
    logic [1:0][4:0]  btn_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_pipe  <= '0;
            btn_pipe <= '0;
        end else begin
            sw_pipe  <= {sw_pipe[0], sw};
            btn_pipe <= {btn_pipe[0], btn};
        end
    end

    logic [TW-1:0] tpre;
    logic [31:0]   timer_q;
    logic          tick;

    assign tick = (tpre == TW'(TICK_DIV - 1));

    // A load discards any tick landing on the same edge and restarts the prescaler
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tpre    <= '0;
            timer_q <= '0;
        end else if (wr_timer) begin
            tpre    <= '0;
            timer_q <= req.wdata;
        end else begin
            tpre <= tick ? '0 : tpre + TW'(1);
            if (tick)
                timer_q <= timer_q + 32'd1;
        end
    end

    always_comb begin
        io_rdata = '0;
        if (req.rd) begin
            case (sel)
                SEL_DIG:   io_rdata = dig_q;
                SEL_TIMER: io_rdata = timer_q;
                SEL_LED:   io_rdata = {8'h0, led_q};
                SEL_SW:    io_rdata = {8'h0, sw_pipe[1]};
                SEL_BTN:   io_rdata = {27'h0, btn_pipe[1]};
                default:   io_rdata = '0;
            endcase
        end
    end

    seg7_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk   (clk),
        .rst_n (rst_n),
        .dig   (dig_q),
        .an    (an),
        .seg   (seg)
    );

endmodule

// File: doc/io_responder.md
# io_responder

Memory-mapped I/O responder for the single-cycle RISC-V SoC. Sits on the CPU's I/O side, opposite the control unit's `IO_rd_e`/`IO_wr_e` strobes, and serves word accesses to the board peripherals:

- 8-digit seven-segment display (scanned)
- LEDs
- switches
- buttons
- millisecond-style tick timer

Reads return combinationally from registered state, so the single-cycle datapath completes loads in the same cycle. Writes commit on the clock edge.

## Interface
Parameters:
- `SCAN_DIV`, default 20000: clk cycles per displayed digit.
- `TICK_DIV`, default 100000: clk cycles per timer increment.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `io_addr`  in  32  byte address of the access.
- `io_rd_e`  in  1  read enable. Also asserted during stores; reads have no side effects.
- `io_wr_e`  in  1  write enable.
- `io_wdata`  in  32  write data.
- `io_rdata`  out  32  read data. Combinational.
- `sw`  in  24  raw switch pins.
- `btn`  in  5  raw button pins.
- `led`  out  24  LED drive.
- `an`  out  8  digit enables, active-low one-hot.
- `seg`  out  8  segments, active-low. Bit 0 = a … bit 6 = g, bit 7 = dp.

## Operation
Address map (full 32-bit compare; all others unmapped):
- `0xFFFF_F000` DIG (R/W): 32-bit value shown as 8 hex digits. Digit *i* shows `DIG[4i+3:4i]`.
- `0xFFFF_F020` TIMER (R/W): a write loads `io_wdata`; a read returns the count.
- `0xFFFF_F060` LED (R/W): bits [23:0] drive `led`. Reads return `{8'h0, led}`.
- `0xFFFF_F070` SW (RO): reads return `{8'h0, sw_sync}`.
- `0xFFFF_F078` BTN (RO): reads return `{27'h0, btn_sync}`.

Access rules:
- `io_rdata` is 0 whenever `io_rd_e` = 0 or the address is unmapped.
- Writes to RO or unmapped addresses are ignored.

Input synchronisation:
- `sw` and `btn` each pass through a 2-flop synchroniser. No debounce.

Scanner:
- Prescaler counts 0..`SCAN_DIV`-1.
- On wrap, the digit index advances 0→1→…→7→0.
- `an` = ~(1<<idx).
- `seg` = hex decode of the selected nibble, dp always off. Required codes: 0=C0, 1=F9, 8=80, F=8E; the rest are standard hex glyphs.

Timer:
- Prescaler counts 0..`TICK_DIV`-1. On wrap, TIMER increments, wrapping mod 2^32.
- A TIMER write loads `io_wdata` and clears the prescaler.
- If a write and a tick fall in the same cycle, the write wins: the loaded value is kept and no increment occurs.

Reset values:
- DIG = 0, LED = 0, TIMER = 0.
- All prescalers and the digit index = 0.
- Synchroniser flops = 0.
- `an` = 8'hFE, `seg` = 8'hC0, `led` = 0.

Reset asserted mid-operation returns all state to these values immediately, with no dependence on `clk`.

## Timing
- Register write: `io_wr_e` sampled at edge N; the new value is visible on `io_rdata` and `led` after edge N.
- `an` and `seg` are registered. A DIG write at edge N changes `seg` at edge N+1. A digit advance computed at edge N appears at edge N+1.
- Each digit is held for exactly `SCAN_DIV` cycles. A full frame is 8·`SCAN_DIV` cycles.
- Pin change to visible on `io_rdata`: 2 edges.
- TIMER increments every `TICK_DIV` cycles. The first increment after a load comes `TICK_DIV` edges after the load edge.
- Read path is pure combinational: no wait states and no handshake.

## Structure
- Shared package `io_pkg` holds:
  - the five address constants
  - the 16-entry hex-to-segment table
  - `SCAN_DIV` and `TICK_DIV` defaults
- Sub-module `seg7_scan` contains the scan prescaler, digit index, nibble select, decode, and the registered `an`/`seg`.
- The top level holds:
  - address decode
  - register file
  - synchronisers
  - timer
  - read mux

## Test plan
Bench uses `SCAN_DIV`=4, `TICK_DIV`=10.

- **Reset:** hold `rst_n`=0, release → `an`=FE, `seg`=C0, `led`=0, reads of DIG/TIMER/LED = 0. Assert `rst_n` mid-scan → outputs return to reset values the same cycle, without a clock edge.
- **Display:** write DIG=0x8000_0001 → digit 0 shows F9, digits 1–6 show C0, digit 7 shows 80. `an` steps FE, FD, …, 7F, then FE, each held exactly 4 cycles.
- **LED and RO:** write LED=0xFFAB_CDEF → `led`=ABCDEF and readback = 0x00AB_CDEF. Write to SW → ignored. Read 0xFFFF_F004 → 0.
- **Sync latency:** set `sw`=0x123456 → SW read still shows the old value after 1 edge and 0x0012_3456 after 2 edges. Same check with `btn`=5'h15 → 0x15.
- **Timer:** write TIMER=0xFFFF_FFFF, wait 10 cycles → 0. Write 5 on the exact cycle of a tick → reads 5, and the next increment is 10 cycles later.
- **Read gating:** `io_rd_e`=0 with a valid address → `io_rdata`=0. A store that also asserts `io_rd_e` → no side effects.
